fu_mul_pipe: RTL and testbench
==============================

// Module: fu_mul_pipe
// PURPOSE
//  Parametrised, pipelined integer multiply FU for the P6 back end (RV32M MUL/MULH/MULHSU/MULHU).
//  Accepts one op per cycle from the RS issue port and iterates the multiplier over STAGES
//  register stages, XLEN/STAGES multiplier bits per stage. The result and ROB tag go to the CDB arbiter.
//  Has per-stage valid/ready backpressure and a full-pipe squash. Single-cycle ALU/branch FUs have neither.
// PARAMETERS
//  XLEN    32  operand/result width
//  STAGES  4   pipeline depth = latency; XLEN % STAGES == 0, 1 <= STAGES <= XLEN
//  TAG_W   5   ROB tag width carried alongside each op
// PORTS
//  clock        in   1       system clock
//  reset        in   1       synchronous, active-high
//  squash       in   1       branch-mispredict flush, synchronous
//  in_valid     in   1       RS presents an op
//  in_ready     out  1       FU accepts op this cycle (in_valid && in_ready = accept)
//  in_func      in   2       MUL_FUNC: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//  in_opa       in   XLEN    rs1 value
//  in_opb       in   XLEN    rs2 value
//  in_tag       in   TAG_W   destination ROB tag
//  out_valid    out  1       result held for CDB
//  out_ready    in   1       CDB grant (out_valid && out_ready = retire from FU)
//  out_result   out  XLEN    selected product half
//  out_tag      out  TAG_W   tag of out_result
//  out_illegal  out  1       op unsupported in this build
//  busy         out  1       OR of all stage valid bits
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, out_result=0, out_tag=0, out_illegal=0, busy=0, in_ready=1.
//  Operand prep in the accept cycle: opa sign-extended to XLEN+1 for MULH/MULHSU, otherwise zero-extended.
//   opb is sign-extended for MULH only. Each stage carries a 2*XLEN+2 accumulator, the shifted
//   multiplicand and the remaining multiplier bits. Stage k adds XLEN/STAGES partial products.
//   The final stage applies the sign correction for a signed opb.
//  Select: MUL gives product[XLEN-1:0]; the other three functions give product[2XLEN-1:XLEN].
//  Latency: accept in cycle t -> out_valid in cycle t+STAGES when there is no backpressure.
//   Throughput is 1 op per cycle.
//  Stage i advances when it is valid and (stage i+1 is empty or stage i+1 advances).
//   The final stage advances on out_ready. in_ready = stage0 empty or stage0 advances.
//   in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
//  Bubbles collapse: an empty stage is refilled regardless of downstream stall.
//  Outputs are registered (last stage). They hold stable while out_valid && !out_ready.
//  Squash: all valids clear at the next edge. The same-cycle accept is discarded,
//   and in_ready and out_valid still report normally in that cycle.
//   A same-cycle out_ready handshake counts as retired.
//  reset has priority over squash. A reset mid-operation drops all in-flight ops with no output.
//  Ops leave in issue order; tags are never reordered or duplicated.
// CONFIGURATION
//  FU_MUL_HIGH_EN defined: all four functions are supported; out_illegal is always 0.
//  FU_MUL_HIGH_EN undefined: only MUL is supported. MULH/MULHSU/MULHU still flow with normal latency,
//   with out_result=0 and out_illegal=1. The datapath is reduced to an XLEN-bit accumulator.
// STRUCTURE
//  Shared package: MUL_FUNC enum, MUL_PIPE_PACKET struct {valid, func, tag, acc, mcand, mplier},
//   and the XLEN_MUL_STAGES_DEFAULT constant.
//  Sub-module mul_stage: one combinational partial-product slice of XLEN/STAGES bits.
//   It is instanced STAGES times in a generate loop; fu_mul_pipe owns the registers and handshake.
// TESTING
//  MUL 7 x -3 tag 4, out_ready=1 -> cycle t+4: out_result=32'hFFFF_FFEB, out_tag=4, out_illegal=0.
//  MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> result 32'hFFFF_FFFE.
//   The same operands with MULH -> 0; with MULHSU -> 32'hFFFF_FFFF.
//  Back-to-back 8 ops, tags 0..7, out_ready=0 for cycles 5-9 -> pipe fills, in_ready=0 after 4 held ops.
//   Releasing out_ready gives tags 0..7 in order, one per cycle, with no loss or duplication.
//  Squash with 3 ops in flight plus an accept in the same cycle -> next cycle busy=0, out_valid=0.
//   No stale tag ever appears afterwards.
//  Reset asserted while out_valid=1 and out_ready=0 -> next cycle all outputs are 0 and in_ready=1.
//  Build without FU_MUL_HIGH_EN: MULH 5 x 6 -> out_illegal=1, out_result=0, latency 4.
//   MUL 5 x 6 -> 30, out_illegal=0.

Source files
------------

// File: rtl/fu_mul_pipe_pkg.sv
// Shared types for the pipelined multiply FU: function encoding, stage packet and default sizes.
// FU_MUL_HIGH_EN selects the full 2*XLEN+2 accumulator; without it the datapath keeps only the low XLEN bits.
package fu_mul_pipe_pkg;

    localparam int MUL_XLEN                = 32;
    localparam int MUL_TAG_W               = 5;
    localparam int XLEN_MUL_STAGES_DEFAULT = 4;

`ifdef FU_MUL_HIGH_EN
    localparam int ACC_W    = 2 * MUL_XLEN + 2;
    localparam int MPLIER_W = MUL_XLEN + 1;
`else
    localparam int ACC_W    = MUL_XLEN;
    localparam int MPLIER_W = MUL_XLEN;
`endif

    typedef enum logic [1:0] {
        MUL_FUNC_MUL    = 2'd0,
        MUL_FUNC_MULH   = 2'd1,
        MUL_FUNC_MULHSU = 2'd2,
        MUL_FUNC_MULHU  = 2'd3
    } mul_func_e;

    // One pipeline slot: partial product so far plus the operand bits still to consume.
    typedef struct packed {
        logic                  valid;
        mul_func_e             func;
        logic [MUL_TAG_W-1:0]  tag;
        logic [ACC_W-1:0]      acc;
        logic [ACC_W-1:0]      mcand;
        logic [MPLIER_W-1:0]   mplier;
    } mul_pipe_packet_t;

endpackage

// File: rtl/fu_mul_pipe_if.sv
// Issue-side and CDB-side handshake bundle of the multiply FU.
interface fu_mul_pipe_if
    import fu_mul_pipe_pkg::*;
#(
    parameter int XLEN  = MUL_XLEN,
    parameter int TAG_W = MUL_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_func;
    logic [XLEN-1:0]  in_opa;
    logic [XLEN-1:0]  in_opb;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_func, in_opa, in_opb, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_func, in_opa, in_opb, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );
endinterface

// File: rtl/fu_mul_pipe_mul_stage.sv
// Combinational shift-add slice: consumes BPS multiplier bits; the last slice also folds in the
// negative weight of a signed multiplier's top bit (always zero when that bit is not carried).
module mul_stage
    import fu_mul_pipe_pkg::*;
#(
    parameter int BPS  = 8,
    parameter bit LAST = 1'b0
) (
    input  mul_pipe_packet_t pkt_i,
    output mul_pipe_packet_t pkt_o
);
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    mcand;
    logic [MPLIER_W-1:0] mplier;

    always_comb begin
        acc    = pkt_i.acc;
        mcand  = pkt_i.mcand;
        mplier = pkt_i.mplier;
        for (int j = 0; j < BPS; j++) begin
            if (mplier[0]) acc = acc + mcand;
            mcand  = mcand << 1;
            mplier = mplier >> 1;
        end
        // After XLEN shifts only the sign bit of the extended multiplier is left in bit 0.
        if (LAST && mplier[0]) acc = acc - mcand;
        pkt_o        = pkt_i;
        pkt_o.acc    = acc;
        pkt_o.mcand  = mcand;
        pkt_o.mplier = mplier;
    end
endmodule

// File: rtl/fu_mul_pipe.sv
// Pipelined RV32M multiply FU with per-stage valid/ready, bubble collapse and full-pipe squash.
// FU_MUL_HIGH_EN enables MULH/MULHSU/MULHU; otherwise those flow through flagged out_illegal.
module fu_mul_pipe
    import fu_mul_pipe_pkg::*;
#(
    parameter int XLEN   = MUL_XLEN,
    parameter int STAGES = XLEN_MUL_STAGES_DEFAULT,
    parameter int TAG_W  = MUL_TAG_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            squash,
    fu_mul_pipe_if.slave    io,
    output logic            busy
);
    localparam int BPS  = XLEN / STAGES;
    localparam int LAST = STAGES - 1;

    mul_pipe_packet_t stage_q    [STAGES];
    mul_pipe_packet_t stage_d    [STAGES];
    mul_pipe_packet_t stage_in   [STAGES];
    mul_pipe_packet_t stage_calc [STAGES];
    mul_pipe_packet_t prep;
    logic [STAGES-1:0] adv;
    logic [STAGES:0]   up_fire;
    logic              in_fire;
    mul_func_e         in_func;
`ifdef FU_MUL_HIGH_EN
    logic              a_sgn;
    logic              b_sgn;
`endif

    always_comb begin
        in_func     = mul_func_e'(io.in_func);
        in_fire     = io.in_valid && io.in_ready;
        prep        = '0;
        prep.valid  = in_fire;
        prep.func   = in_func;
        prep.tag    = io.in_tag;
`ifdef FU_MUL_HIGH_EN
        a_sgn       = (in_func == MUL_FUNC_MULH) || (in_func == MUL_FUNC_MULHSU);
        b_sgn       = (in_func == MUL_FUNC_MULH);
        prep.mcand  = {{(ACC_W - XLEN){a_sgn & io.in_opa[XLEN-1]}}, io.in_opa};
        prep.mplier = {b_sgn & io.in_opb[XLEN-1], io.in_opb};
`else
        prep.mcand  = io.in_opa;
        prep.mplier = io.in_opb;
`endif
    end

    // A stage advances iff some stage downstream of it is empty or the CDB grants.
    always_comb begin
        logic room;
        room = io.out_ready;
        adv  = '0;
        for (int i = LAST; i >= 0; i--) begin
            adv[i] = stage_q[i].valid && room;
            room   = room || !stage_q[i].valid;
        end
        io.in_ready = room;
    end

    always_comb begin
        up_fire = {adv, in_fire};
        busy    = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            busy       = busy || stage_q[i].valid;
            stage_d[i] = stage_q[i];
            if (!stage_q[i].valid || adv[i]) begin
                stage_d[i]       = stage_calc[i];
                stage_d[i].valid = up_fire[i];
            end
            if (squash) stage_d[i].valid = 1'b0;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_in[g] = prep;
        end else begin : g_body
            assign stage_in[g] = stage_q[g-1];
        end
        mul_stage #(.BPS(BPS), .LAST(g == LAST)) u_mul_stage (
            .pkt_i (stage_in[g]),
            .pkt_o (stage_calc[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage_q[i].valid <= 1'b0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Outputs come straight from the last stage register, zeroed while it is empty.
    always_comb begin
        io.out_valid   = stage_q[LAST].valid;
        io.out_tag     = stage_q[LAST].valid ? TAG_W'(stage_q[LAST].tag) : '0;
        io.out_result  = '0;
`ifdef FU_MUL_HIGH_EN
        io.out_illegal = 1'b0;
        if (stage_q[LAST].valid) begin
            io.out_result = (stage_q[LAST].func == MUL_FUNC_MUL) ? stage_q[LAST].acc[XLEN-1:0]
                                                                 : stage_q[LAST].acc[2*XLEN-1:XLEN];
        end
`else
        io.out_illegal = stage_q[LAST].valid && (stage_q[LAST].func != MUL_FUNC_MUL);
        if (stage_q[LAST].valid && stage_q[LAST].func == MUL_FUNC_MUL) begin
            io.out_result = stage_q[LAST].acc[XLEN-1:0];
        end
`endif
    end
endmodule

// File: tb/tb_fu_mul_pipe.sv
// Self-checking bench for fu_mul_pipe: directed cases plus randomized traffic against a queue model.
module tb_fu_mul_pipe;
    import fu_mul_pipe_pkg::*;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 5;
    localparam int STAGES = 4;
`ifdef FU_MUL_HIGH_EN
    localparam bit HIGH = 1'b1;
`else
    localparam bit HIGH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic squash;
    logic busy;

    fu_mul_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) io ();

    fu_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock  (clk),
        .reset  (reset),
        .squash (squash),
        .io     (io),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t             exp_q[$];
    logic [TAG_W-1:0] ret_tags[$];
    int               ret_cyc[$];
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               n_acc;
    bit               rand_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full 64-bit product of the architecturally extended operands.
    function automatic exp_t model(input logic [1:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        exp_t        e;
        logic [63:0] ea, eb, p;
        ea = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        e.tag = t;
        if (f == 2'd0) begin
            e.res = p[31:0];
            e.ill = 1'b0;
        end else if (HIGH) begin
            e.res = p[63:32];
            e.ill = 1'b0;
        end else begin
            e.res = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: retire check, then squash/reset flush, then record new accepts.
    logic             hold_v = 1'b0;
    logic [XLEN-1:0]  hold_res;
    logic [TAG_W-1:0] hold_tag;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v && io.out_valid) begin
                check("hold_result", io.out_result, hold_res);
                check("hold_tag", io.out_tag, hold_tag);
            end
            hold_v   = io.out_valid && !io.out_ready && !squash;
            hold_res = io.out_result;
            hold_tag = io.out_tag;
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", io.out_result, e.res);
                    check("sb_tag", io.out_tag, e.tag);
                    check("sb_illegal", io.out_illegal, e.ill);
                end
                ret_tags.push_back(io.out_tag);
                ret_cyc.push_back(cyc);
            end
            if (squash) exp_q.delete();
            else if (io.in_valid && io.in_ready)
                exp_q.push_back(model(io.in_func, io.in_opa, io.in_opb, io.in_tag));
        end
    end

    task automatic drive_op(input mul_func_e f, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        bit done;
        done        = 1'b0;
        io.in_valid = 1'b1;
        io.in_func  = f;
        io.in_opa   = a;
        io.in_opb   = b;
        io.in_tag   = t;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (io.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
        io.in_valid = 1'b0;
    endtask

    task automatic run_one(input mul_func_e f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [TAG_W-1:0] t, input logic [XLEN-1:0] er, input logic ei);
        drive_op(f, a, b, t);
        for (int k = 0; k < STAGES - 1; k++) begin
            @(negedge clk);
            check("latency_early", io.out_valid, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("latency_valid", io.out_valid, 1);
        check("dir_result", io.out_result, er);
        check("dir_tag", io.out_tag, t);
        check("dir_illegal", io.out_illegal, ei);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset        = 1'b1;
        squash       = 1'b0;
        io.in_valid  = 1'b0;
        io.in_func   = 2'd0;
        io.in_opa    = '0;
        io.in_opb    = '0;
        io.in_tag    = '0;
        io.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_out_result", io.out_result, 0);
        check("rst_out_tag", io.out_tag, 0);
        check("rst_out_illegal", io.out_illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", io.in_ready, 1);
        @(posedge clk);
        #1 io.out_ready = 1'b1;

        run_one(MUL_FUNC_MUL,    32'd7, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, 1'b0);
        run_one(MUL_FUNC_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, HIGH ? 32'hFFFF_FFFE : 32'h0, !HIGH);
        run_one(MUL_FUNC_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0, !HIGH);
        run_one(MUL_FUNC_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, HIGH ? 32'hFFFF_FFFF : 32'h0, !HIGH);
        run_one(MUL_FUNC_MULH,   32'd5, 32'd6, 5'd5, 32'h0, !HIGH);
        run_one(MUL_FUNC_MUL,    32'd5, 32'd6, 5'd6, 32'd30, 1'b0);

        // Backpressure: stall the CDB, fill the pipe, then release.
        ret_tags.delete();
        ret_cyc.delete();
        n_acc = 0;
        io.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    drive_op(MUL_FUNC_MUL, 32'(i + 3), 32'(i * 7 + 1), 5'(i));
                    n_acc++;
                end
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", io.in_ready, 0);
                check("bp_accepted", n_acc, 4);
                check("bp_busy", busy, 1);
                @(posedge clk);
                #1 io.out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && ret_tags.size() < 8; k++) @(posedge clk);
        #1;
        check("bp_count", ret_tags.size(), 8);
        for (int i = 0; i < 8 && i < ret_tags.size(); i++) begin
            check("bp_order", ret_tags[i], i);
            check("bp_spacing", ret_cyc[i] - ret_cyc[0], i);
        end

        // Squash with three ops in flight and an accept in the same cycle.
        drive_op(MUL_FUNC_MUL, 32'd11, 32'd12, 5'd20);
        drive_op(MUL_FUNC_MUL, 32'd13, 32'd14, 5'd21);
        drive_op(MUL_FUNC_MUL, 32'd15, 32'd16, 5'd22);
        io.in_valid = 1'b1;
        io.in_tag   = 5'd23;
        squash      = 1'b1;
        @(negedge clk);
        check("sq_in_ready", io.in_ready, 1);
        check("sq_busy_before", busy, 1);
        @(posedge clk);
        #1;
        squash      = 1'b0;
        io.in_valid = 1'b0;
        @(negedge clk);
        check("sq_busy", busy, 0);
        check("sq_out_valid", io.out_valid, 0);
        repeat (6) begin
            @(negedge clk);
            check("sq_stale", io.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Reset while a result is held un-granted.
        io.out_ready = 1'b0;
        drive_op(MUL_FUNC_MUL, 32'd9, 32'd9, 5'd25);
        drive_op(MUL_FUNC_MUL, 32'd8, 32'd8, 5'd26);
        for (int k = 0; k < 20 && !io.out_valid; k++) @(negedge clk);
        check("rm_held_valid", io.out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rm_out_valid", io.out_valid, 0);
        check("rm_out_result", io.out_result, 0);
        check("rm_out_tag", io.out_tag, 0);
        check("rm_out_illegal", io.out_illegal, 0);
        check("rm_busy", busy, 0);
        check("rm_in_ready", io.in_ready, 1);
        io.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rm_no_output", io.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random CDB stalls and occasional squash.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    drive_op(mul_func_e'($urandom_range(0, 3)), rand_op(), rand_op(), 5'(i));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    io.out_ready = ($urandom_range(0, 3) != 0);
                    squash       = ($urandom_range(0, 60) == 0);
                end
            end
        join
        squash       = 1'b0;
        io.out_ready = 1'b1;
        for (int k = 0; k < 50 && busy; k++) @(posedge clk);
        @(negedge clk);
        check("drain_busy", busy, 0);
        check("drain_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
